config_regfile: RTL and testbench
=================================

Name: config_regfile

Overview:
- Parametrised memory-mapped control/status register file; slave on MemoryBus.
- Successor to the fixed-map raytracer config block.
- Provides NUM_REGS generic r/w registers, start/flush/soft-reset pulses, masked edge-triggered interrupt status with write-1-to-clear, and a RESP_DEPTH-entry read-response FIFO so reads can be pipelined back-to-back.
- Sits between the bus fabric and any accelerator core (raytracer, blitter, DMA).

Parameters:
DATA_WIDTH, 24, bus data width
ADDRESS_WIDTH, 32, bus address width
ADDRESS, 0, block select; matches msAddress[ADDRESS_WIDTH-1:BASE_WIDTH]
BASE_WIDTH, 5, offset bits; NUM_REGS+4 <= 2**BASE_WIDTH
NUM_REGS, 16, generic registers at offsets 4..NUM_REGS+3
NUM_IRQ, 4, interrupt sources, 1..DATA_WIDTH
RESP_DEPTH, 4, read-response FIFO entries, power of two, >= 2
VERSION, 0, constant returned at offset 3

Ports:
clock  input  1  clock
reset  input  1  synchronous, active-high reset
regs  output  NUM_REGS x DATA_WIDTH  generic register contents
start  output  1  one-cycle pulse
flush  output  1  one-cycle pulse
resetCore  output  1  soft-reset pulse, ORed with reset
ready  input  1  core status, readable
busy  input  1  core status, readable
irqSources  input  NUM_IRQ  level sources, rising edge latched
interrupt  output  1  level, |(irqStatus & irqEnable)
bus  MemoryBus.Slave  -  msAddress/msData/msWrite/msValid/msTaken/msID; smData/smValid/smTaken/smID

Behaviour:
- hit = msValid && msAddress[ADDRESS_WIDTH-1:BASE_WIDTH]==ADDRESS; off = msAddress[BASE_WIDTH-1:0].
- msTaken (combinational):
  - Writes: hit.
  - Reads: hit && !fifoFull.
  - A pop in the same cycle does not unblock a full FIFO.
- Accepted write, effective next edge:
  - Offset 0 CONTROL: combinational same-cycle pulses start=msData[0], flush=msData[2], resetCore=msData[1]|reset. All three are 0 otherwise, except resetCore=reset.
  - Offset 1 IRQ_STATUS: bits written 1 clear.
  - Offset 2 IRQ_ENABLE: load low NUM_IRQ bits.
  - Offset 3: ignored.
  - Offset 4+k (k<NUM_REGS): regs[k] <= msData.
  - Offsets above NUM_REGS+3: ignored.
- Accepted read: captures data and msID into the FIFO tail on that edge.
  - Offset 0: {busy, ready} in bits [1:0], zero-extended.
  - Offset 1: irqStatus.
  - Offset 2: irqEnable.
  - Offset 3: VERSION.
  - Offset 4+k: regs[k].
  - Unmapped offsets: 0.
  - Captured value is the pre-edge register state.
- Response channel:
  - smValid = !fifoEmpty; smData/smID come from the FIFO head.
  - Pop on smValid && smTaken.
  - Minimum latency is 1 cycle (accept at edge N, smValid high after edge N).
  - Responses are returned in acceptance order.
  - Head data is stable while smValid && !smTaken.
- Simultaneous push and pop when not full: both occur; count unchanged.
- IRQ:
  - irqPrev <= irqSources each cycle.
  - Status bit sets on a 0->1 edge.
  - Set and W1C on the same bit in the same cycle: set wins.
  - interrupt is a registered-status-derived level; no pulse.
- Reset: regs, irqStatus, irqEnable, irqPrev and FIFO pointers go to 0. smValid=0, start=0, flush=0, resetCore=1.
  - Reset mid-operation discards queued responses; no smValid after reset until a new read is accepted.
- Pointers: log2(RESP_DEPTH)+1 bits; wrap naturally; full when MSBs differ and the rest are equal.

Optional Feature:
- Macro: CONFIG_REGFILE_WRITE_ACK_EN.
- When defined:
  - Every accepted write also pushes a response (smData=0, smID=msID).
  - Writes are then also gated by !fifoFull.
  - Write responses are interleaved in order with read responses.
- When undefined: writes produce no response and are never back-pressured.

Test Plan:
- Reset, write 0x123456 to offset 5, read offset 5 with msID=3 -> msTaken same cycle, smValid next cycle, smData=0x123456, smID=3; regs[1]=0x123456.
- Four back-to-back reads (offsets 3,4,1,2) with smTaken=0, RESP_DEPTH=4 -> all taken; a 5th read sees msTaken=0. Drain with smTaken=1 -> in-order data (VERSION, regs[0], irqStatus, irqEnable) and IDs; 5th read accepted after the first pop.
- Write 0x000005 to offset 0 -> start=1 and flush=1 for exactly that cycle, resetCore=0. Write 0x2 -> resetCore=1 for one cycle.
- irqEnable=0x1; pulse irqSources[0] -> interrupt=1 next cycle. Write 0x1 to offset 1 in the same cycle as a new irqSources[0] edge -> status stays 1. Write 0x1 later -> interrupt=0.
- Assert reset with 2 queued responses -> smValid=0 after the edge; regs=0; reading offset 4 returns 0.
- With CONFIG_REGFILE_WRITE_ACK_EN: fill the FIFO with reads, then issue a write -> msTaken=0 until a pop; the write ack arrives with smData=0 and the write's msID.

Source files
------------

// File: rtl/config_regfile.sv
// Parametrised control/status register file with the MemoryBus slave signals flattened into ms*/sm* ports.
// Optional build macro CONFIG_REGFILE_WRITE_ACK_EN: writes also return a zero-data response through the read FIFO.
module config_regfile #(
    parameter int unsigned DATA_WIDTH    = 24,
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned ADDRESS       = 0,
    parameter int unsigned BASE_WIDTH    = 5,
    parameter int unsigned NUM_REGS      = 16,
    parameter int unsigned NUM_IRQ       = 4,
    parameter int unsigned RESP_DEPTH    = 4,
    parameter int unsigned VERSION       = 0,
    parameter int unsigned ID_WIDTH      = 4
) (
    input  logic                                clock,
    input  logic                                reset,
    output logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_o,
    output logic                                start_o,
    output logic                                flush_o,
    output logic                                resetCore_o,
    input  logic                                ready_i,
    input  logic                                busy_i,
    input  logic [NUM_IRQ-1:0]                  irqSources_i,
    output logic                                interrupt_o,
    input  logic [ADDRESS_WIDTH-1:0]            msAddress_i,
    input  logic [DATA_WIDTH-1:0]               msData_i,
    input  logic                                msWrite_i,
    input  logic                                msValid_i,
    output logic                                msTaken_o,
    input  logic [ID_WIDTH-1:0]                 msID_i,
    output logic [DATA_WIDTH-1:0]               smData_o,
    output logic                                smValid_o,
    input  logic                                smTaken_i,
    output logic [ID_WIDTH-1:0]                 smID_o
);
    localparam int unsigned PTR_W  = $clog2(RESP_DEPTH);
    localparam int unsigned SEL_W  = ADDRESS_WIDTH - BASE_WIDTH;
    localparam int unsigned RIDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    localparam logic [SEL_W-1:0]      BLOCK_SEL      = SEL_W'(ADDRESS);
    localparam logic [BASE_WIDTH-1:0] OFF_CONTROL    = BASE_WIDTH'(0);
    localparam logic [BASE_WIDTH-1:0] OFF_IRQ_STATUS = BASE_WIDTH'(1);
    localparam logic [BASE_WIDTH-1:0] OFF_IRQ_ENABLE = BASE_WIDTH'(2);
    localparam logic [BASE_WIDTH-1:0] OFF_VERSION    = BASE_WIDTH'(3);
    localparam logic [BASE_WIDTH-1:0] OFF_REG_LO     = BASE_WIDTH'(4);
    localparam logic [BASE_WIDTH-1:0] OFF_REG_HI     = BASE_WIDTH'(NUM_REGS + 3);

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
    logic [NUM_IRQ-1:0]                  irq_status_q, irq_status_d;
    logic [NUM_IRQ-1:0]                  irq_enable_q, irq_enable_d;
    logic [NUM_IRQ-1:0]                  irq_prev_q;
    logic [NUM_IRQ-1:0]                  irq_clear;
    logic [PTR_W:0]                      wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]                      rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0]               fifo_data_q [RESP_DEPTH];
    logic [ID_WIDTH-1:0]                 fifo_id_q   [RESP_DEPTH];

    logic                  hit, is_reg, wr_accept, ctrl_wr;
    logic                  fifo_full, fifo_empty, push, pop;
    logic [BASE_WIDTH-1:0] off;
    logic [RIDX_W-1:0]     reg_idx;
    logic [DATA_WIDTH-1:0] rd_data, push_data;

    assign off     = msAddress_i[BASE_WIDTH-1:0];
    assign hit     = msValid_i && (msAddress_i[ADDRESS_WIDTH-1:BASE_WIDTH] == BLOCK_SEL);
    assign is_reg  = (off >= OFF_REG_LO) && (off <= OFF_REG_HI);
    assign reg_idx = RIDX_W'(off - OFF_REG_LO);

    // Full when the wrap bits differ and the index bits match; empty when the pointers are identical.
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);

`ifdef CONFIG_REGFILE_WRITE_ACK_EN
    assign msTaken_o = hit && !fifo_full;
    assign push      = msTaken_o;
    assign push_data = msWrite_i ? '0 : rd_data;
`else
    assign msTaken_o = hit && (msWrite_i || !fifo_full);
    assign push      = msTaken_o && !msWrite_i;
    assign push_data = rd_data;
`endif

    assign wr_accept = msTaken_o && msWrite_i;
    assign pop       = !fifo_empty && smTaken_i;

    assign ctrl_wr     = wr_accept && (off == OFF_CONTROL) && !reset;
    assign start_o     = ctrl_wr && msData_i[0];
    assign flush_o     = ctrl_wr && msData_i[2];
    assign resetCore_o = reset || (ctrl_wr && msData_i[1]);

    assign interrupt_o = |(irq_status_q & irq_enable_q);
    assign regs_o      = regs_q;
    assign smValid_o   = !fifo_empty;
    assign smData_o    = fifo_data_q[rd_ptr_q[PTR_W-1:0]];
    assign smID_o      = fifo_id_q[rd_ptr_q[PTR_W-1:0]];

    // NOTE: every signal written here gets a default first, so no path can leave it holding a value (no latch).
    always_comb begin
        rd_data = '0;
        if (off == OFF_CONTROL) begin
            rd_data[1:0] = {busy_i, ready_i};
        end else if (off == OFF_IRQ_STATUS) begin
            rd_data[NUM_IRQ-1:0] = irq_status_q;
        end else if (off == OFF_IRQ_ENABLE) begin
            rd_data[NUM_IRQ-1:0] = irq_enable_q;
        end else if (off == OFF_VERSION) begin
            rd_data = DATA_WIDTH'(VERSION);
        end else if (is_reg) begin
            rd_data = regs_q[reg_idx];
        end
    end

    always_comb begin
        irq_clear    = '0;
        irq_enable_d = irq_enable_q;
        regs_d       = regs_q;
        if (wr_accept && (off == OFF_IRQ_STATUS)) irq_clear = msData_i[NUM_IRQ-1:0];
        if (wr_accept && (off == OFF_IRQ_ENABLE)) irq_enable_d = msData_i[NUM_IRQ-1:0];
        if (wr_accept && is_reg) regs_d[reg_idx] = msData_i;
        // A fresh rising edge is ORed in after the clear, so set beats write-1-to-clear.
        irq_status_d = (irq_status_q & ~irq_clear) | (irqSources_i & ~irq_prev_q);
        wr_ptr_d     = wr_ptr_q + (PTR_W + 1)'(push);
        rd_ptr_d     = rd_ptr_q + (PTR_W + 1)'(pop);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            regs_q       <= '0;
            irq_status_q <= '0;
            irq_enable_q <= '0;
            irq_prev_q   <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            regs_q       <= regs_d;
            irq_status_q <= irq_status_d;
            irq_enable_q <= irq_enable_d;
            irq_prev_q   <= irqSources_i;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
        end
    end

    // NOTE: FIFO storage is deliberately not reset; resetting the pointers is enough to make its contents invisible.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_data_q[wr_ptr_q[PTR_W-1:0]] <= push_data;
            fifo_id_q[wr_ptr_q[PTR_W-1:0]]   <= msID_i;
        end
    end
endmodule

// File: tb/tb_config_regfile.sv
// Self-checking bench for config_regfile: directed scenarios plus a randomized run against a queue-based model.
`timescale 1ns/1ps
module tb_config_regfile;
    localparam int DW  = 24;
    localparam int AW  = 32;
    localparam int BW  = 5;
    localparam int NR  = 16;
    localparam int NI  = 4;
    localparam int RD  = 4;
    localparam int IDW = 4;
    localparam int VER = 'hA5C3;

    logic                    clock = 1'b0;
    logic                    reset = 1'b1;
    logic [NR-1:0][DW-1:0]   regs;
    logic                    start, flush, reset_core, irq_out;
    logic                    ready, busy;
    logic [NI-1:0]           irq_src;
    logic [AW-1:0]           ms_address;
    logic [DW-1:0]           ms_data;
    logic                    ms_write, ms_valid, ms_taken;
    logic [IDW-1:0]          ms_id;
    logic [DW-1:0]           sm_data;
    logic                    sm_valid, sm_taken;
    logic [IDW-1:0]          sm_id;

    config_regfile #(
        .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .ADDRESS(0), .BASE_WIDTH(BW),
        .NUM_REGS(NR), .NUM_IRQ(NI), .RESP_DEPTH(RD), .VERSION(VER), .ID_WIDTH(IDW)
    ) dut (
        .clock(clock), .reset(reset), .regs_o(regs),
        .start_o(start), .flush_o(flush), .resetCore_o(reset_core),
        .ready_i(ready), .busy_i(busy), .irqSources_i(irq_src), .interrupt_o(irq_out),
        .msAddress_i(ms_address), .msData_i(ms_data), .msWrite_i(ms_write), .msValid_i(ms_valid),
        .msTaken_o(ms_taken), .msID_i(ms_id),
        .smData_o(sm_data), .smValid_o(sm_valid), .smTaken_i(sm_taken), .smID_o(sm_id)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog");
    end

    // Behavioural model: register map as arrays, read responses as a queue.
    typedef struct packed { logic [DW-1:0] data; logic [IDW-1:0] id; } resp_t;
    logic [DW-1:0] m_regs [NR];
    logic [NI-1:0] m_status, m_enable, m_prev;
    resp_t         m_q [$];
    int            checks = 0;
    int            errors = 0;

    function automatic int cur_off();
        return int'(ms_address[BW-1:0]);
    endfunction

    function automatic bit m_taken();
        bit hit;
        hit = ms_valid && (ms_address[AW-1:BW] == '0);
        if (!hit) return 1'b0;
`ifdef CONFIG_REGFILE_WRITE_ACK_EN
        return m_q.size() < RD;
`else
        return ms_write || (m_q.size() < RD);
`endif
    endfunction

    function automatic logic [DW-1:0] m_rdval(int off);
        if (off == 0) return DW'({busy, ready});
        if (off == 1) return DW'(m_status);
        if (off == 2) return DW'(m_enable);
        if (off == 3) return DW'(VER);
        if (off >= 4 && off < NR + 4) return m_regs[off-4];
        return '0;
    endfunction

    function automatic bit m_ctrl(int b);
        return m_taken() && ms_write && (cur_off() == 0) && !reset && ms_data[b];
    endfunction

    // Advance one clock: compute the model's next state from pre-edge values, commit at the edge.
    task automatic tick();
        bit            tk, do_push, do_pop;
        resp_t         r, tmp;
        int            off;
        logic [NI-1:0] clr, nstat;
        off    = cur_off();
        tk     = m_taken();
        do_pop = (m_q.size() > 0) && sm_taken;
`ifdef CONFIG_REGFILE_WRITE_ACK_EN
        do_push = tk;
        r.data  = ms_write ? '0 : m_rdval(off);
`else
        do_push = tk && !ms_write;
        r.data  = m_rdval(off);
`endif
        r.id  = ms_id;
        clr   = (tk && ms_write && off == 1) ? ms_data[NI-1:0] : '0;
        nstat = (m_status & ~clr) | (irq_src & ~m_prev);
        @(posedge clock);
        if (reset) begin
            for (int k = 0; k < NR; k++) m_regs[k] = '0;
            m_status = '0;
            m_enable = '0;
            m_prev   = '0;
            m_q.delete();
        end else begin
            if (do_pop) tmp = m_q.pop_front();
            if (do_push) m_q.push_back(r);
            if (tk && ms_write && off == 2) m_enable = ms_data[NI-1:0];
            if (tk && ms_write && off >= 4 && off < NR + 4) m_regs[off-4] = ms_data;
            m_status = nstat;
            m_prev   = irq_src;
        end
        @(negedge clock);
    endtask

    task automatic bus_idle();
        ms_valid = 1'b0; ms_write = 1'b0; ms_address = '0; ms_data = '0; ms_id = '0;
    endtask

    task automatic set_wr(int off, logic [DW-1:0] d, logic [IDW-1:0] id);
        ms_valid = 1'b1; ms_write = 1'b1; ms_address = AW'(off); ms_data = d; ms_id = id;
    endtask

    task automatic set_rd(int off, logic [IDW-1:0] id);
        ms_valid = 1'b1; ms_write = 1'b0; ms_address = AW'(off); ms_data = '0; ms_id = id;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus_idle();
        tick();
        tick();
        #1;
        checks++; if (sm_valid !== 1'b0) begin errors++; $display("FAIL rst_smvalid: got %b expected 0", sm_valid); end
        checks++; if (start !== 1'b0 || flush !== 1'b0) begin errors++; $display("FAIL rst_pulses: got start=%b flush=%b expected 0 0", start, flush); end
        checks++; if (reset_core !== 1'b1) begin errors++; $display("FAIL rst_resetcore: got %b expected 1", reset_core); end
        for (int k = 0; k < NR; k++) begin
            checks++; if (regs[k] !== m_regs[k]) begin errors++; $display("FAIL rst_regs[%0d]: got %h expected %h", k, regs[k], m_regs[k]); end
        end
        reset = 1'b0;
        #1;
        checks++; if (reset_core !== 1'b0) begin errors++; $display("FAIL rst_release_resetcore: got %b expected 0", reset_core); end
        checks++; if (irq_out !== 1'b0) begin errors++; $display("FAIL rst_interrupt: got %b expected 0", irq_out); end
    endtask

    task automatic test_write_read();
        sm_taken = 1'b1;
        set_wr(5, 24'h123456, 4'd0);
        #1;
        checks++; if (ms_taken !== 1'b1) begin errors++; $display("FAIL wr_taken: got %b expected 1", ms_taken); end
        tick();
        set_rd(5, 4'd3);
        #1;
        checks++; if (ms_taken !== 1'b1) begin errors++; $display("FAIL rd_taken: got %b expected 1", ms_taken); end
        checks++; if (sm_valid !== (m_q.size() != 0)) begin errors++; $display("FAIL rd_not_yet_valid: got %b expected %b", sm_valid, m_q.size() != 0); end
        tick();
        bus_idle();
        #1;
        checks++; if (sm_valid !== 1'b1) begin errors++; $display("FAIL rd_latency: got smValid=%b expected 1", sm_valid); end
        checks++; if (sm_data !== 24'h123456) begin errors++; $display("FAIL rd_data: got %h expected 123456", sm_data); end
        checks++; if (sm_id !== 4'd3) begin errors++; $display("FAIL rd_id: got %0d expected 3", sm_id); end
        checks++; if (regs[1] !== 24'h123456) begin errors++; $display("FAIL regs1: got %h expected 123456", regs[1]); end
        tick();
        #1;
        checks++; if (sm_valid !== 1'b0) begin errors++; $display("FAIL rd_pop: got smValid=%b expected 0", sm_valid); end
    endtask

    task automatic test_backpressure();
        int offs [4] = '{3, 4, 1, 2};
        sm_taken = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_rd(offs[i], IDW'(i + 1));
            #1;
            checks++; if (ms_taken !== 1'b1) begin errors++; $display("FAIL bp_accept%0d: got %b expected 1", i, ms_taken); end
            tick();
        end
        set_rd(5, 4'd5);
        #1;
        checks++; if (ms_taken !== 1'b0) begin errors++; $display("FAIL bp_full: got %b expected 0", ms_taken); end
        tick();
        sm_taken = 1'b1;
        #1;
        checks++; if (ms_taken !== 1'b0) begin errors++; $display("FAIL bp_pop_same_cycle: got %b expected 0", ms_taken); end
        checks++; if (sm_data !== DW'(VER) || sm_id !== 4'd1) begin errors++; $display("FAIL bp_head: got %h/%0d expected %h/1", sm_data, sm_id, DW'(VER)); end
        tick();
        #1;
        checks++; if (ms_taken !== 1'b1) begin errors++; $display("FAIL bp_after_pop: got %b expected 1", ms_taken); end
        tick();
        bus_idle();
        for (int n = 0; n < 12 && m_q.size() > 0; n++) begin
            #1;
            checks++; if (sm_valid !== 1'b1 || sm_data !== m_q[0].data || sm_id !== m_q[0].id) begin
                errors++; $display("FAIL bp_drain%0d: got v=%b %h/%0d expected v=1 %h/%0d", n, sm_valid, sm_data, sm_id, m_q[0].data, m_q[0].id);
            end
            tick();
        end
        #1;
        checks++; if (sm_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b expected 0", sm_valid); end
    endtask

    task automatic test_control();
        sm_taken = 1'b1;
        set_wr(0, 24'h000005, 4'd1);
        #1;
        checks++; if (start !== 1'b1 || flush !== 1'b1 || reset_core !== 1'b0) begin
            errors++; $display("FAIL ctrl_5: got s=%b f=%b r=%b expected 1 1 0", start, flush, reset_core);
        end
        tick();
        bus_idle();
        #1;
        checks++; if (start !== 1'b0 || flush !== 1'b0) begin errors++; $display("FAIL ctrl_5_end: got s=%b f=%b expected 0 0", start, flush); end
        set_wr(0, 24'h000002, 4'd2);
        #1;
        checks++; if (reset_core !== 1'b1 || start !== 1'b0 || flush !== 1'b0) begin
            errors++; $display("FAIL ctrl_2: got s=%b f=%b r=%b expected 0 0 1", start, flush, reset_core);
        end
        tick();
        set_wr(0, 24'h000007, 4'd3);
        ms_address = 32'h0000_0020;
        #1;
        checks++; if (ms_taken !== 1'b0 || start !== 1'b0 || reset_core !== 1'b0) begin
            errors++; $display("FAIL ctrl_miss: got t=%b s=%b r=%b expected 0 0 0", ms_taken, start, reset_core);
        end
        tick();
        bus_idle();
        tick();
        tick();
    endtask

    task automatic test_irq();
        sm_taken = 1'b1;
        irq_src  = '0;
        set_wr(2, 24'h1, 4'd0);
        tick();
        bus_idle();
        irq_src = 4'b0001;
        #1;
        checks++; if (irq_out !== 1'b0) begin errors++; $display("FAIL irq_not_comb: got %b expected 0", irq_out); end
        tick();
        #1;
        checks++; if (irq_out !== 1'b1) begin errors++; $display("FAIL irq_set: got %b expected 1", irq_out); end
        irq_src = 4'b0000;
        tick();
        irq_src = 4'b0001;
        set_wr(1, 24'h1, 4'd0);
        tick();
        bus_idle();
        #1;
        checks++; if (irq_out !== 1'b1) begin errors++; $display("FAIL irq_set_wins: got %b expected 1", irq_out); end
        set_rd(1, 4'd6);
        tick();
        bus_idle();
        #1;
        checks++; if (sm_data !== 24'h000001 || sm_id !== 4'd6) begin errors++; $display("FAIL irq_status_read: got %h/%0d expected 000001/6", sm_data, sm_id); end
        tick();
        set_wr(1, 24'h1, 4'd0);
        tick();
        bus_idle();
        #1;
        checks++; if (irq_out !== 1'b0) begin errors++; $display("FAIL irq_w1c: got %b expected 0", irq_out); end
        irq_src = 4'b0011;
        tick();
        #1;
        checks++; if (irq_out !== 1'b0) begin errors++; $display("FAIL irq_masked: got %b expected 0", irq_out); end
        set_wr(2, 24'h2, 4'd0);
        tick();
        bus_idle();
        #1;
        checks++; if (irq_out !== 1'b1) begin errors++; $display("FAIL irq_enable_late: got %b expected 1", irq_out); end
        irq_src = 4'b0000;
        set_wr(1, 24'hF, 4'd0);
        tick();
        bus_idle();
        #1;
        checks++; if (irq_out !== 1'b0) begin errors++; $display("FAIL irq_clear_all: got %b expected 0", irq_out); end
        tick();
        tick();
    endtask

    task automatic test_reset_midop();
        sm_taken = 1'b1;
        set_wr(4, 24'hABCDEF, 4'd0);
        tick();
        bus_idle();
        tick();
        sm_taken = 1'b0;
        set_rd(4, 4'd7);
        tick();
        set_rd(1, 4'd8);
        tick();
        bus_idle();
        #1;
        checks++; if (sm_valid !== 1'b1) begin errors++; $display("FAIL mid_queued: got %b expected 1", sm_valid); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        checks++; if (sm_valid !== 1'b0) begin errors++; $display("FAIL mid_flushed: got %b expected 0", sm_valid); end
        checks++; if (regs !== '0) begin errors++; $display("FAIL mid_regs_zero: got regs[0]=%h expected 0", regs[0]); end
        checks++; if (irq_out !== 1'b0) begin errors++; $display("FAIL mid_irq: got %b expected 0", irq_out); end
        tick();
        #1;
        checks++; if (sm_valid !== 1'b0) begin errors++; $display("FAIL mid_stay_empty: got %b expected 0", sm_valid); end
        sm_taken = 1'b1;
        set_rd(4, 4'd9);
        tick();
        bus_idle();
        #1;
        checks++; if (sm_valid !== 1'b1 || sm_data !== 24'h0 || sm_id !== 4'd9) begin
            errors++; $display("FAIL mid_read_after: got v=%b %h/%0d expected v=1 000000/9", sm_valid, sm_data, sm_id);
        end
        tick();
    endtask

    task automatic test_write_vs_full();
        logic [DW-1:0]  last_data;
        logic [IDW-1:0] last_id;
        int             seen;
        last_data = 'x;
        last_id   = 'x;
        seen      = 0;
        sm_taken  = 1'b0;
        for (int i = 0; i < RD; i++) begin
            set_rd(4 + i, IDW'(i + 1));
            tick();
        end
        set_wr(6, 24'h000777, 4'hA);
        #1;
`ifdef CONFIG_REGFILE_WRITE_ACK_EN
        checks++; if (ms_taken !== 1'b0) begin errors++; $display("FAIL ack_full_block: got %b expected 0", ms_taken); end
        tick();
        sm_taken = 1'b1;
        #1;
        checks++; if (ms_taken !== 1'b0) begin errors++; $display("FAIL ack_pop_same_cycle: got %b expected 0", ms_taken); end
        tick();
        #1;
        checks++; if (ms_taken !== 1'b1) begin errors++; $display("FAIL ack_accept: got %b expected 1", ms_taken); end
        tick();
`else
        checks++; if (ms_taken !== 1'b1) begin errors++; $display("FAIL wr_no_backpressure: got %b expected 1", ms_taken); end
        tick();
        sm_taken = 1'b1;
`endif
        bus_idle();
        for (int n = 0; n < 12 && m_q.size() > 0; n++) begin
            #1;
            checks++; if (sm_valid !== 1'b1 || sm_data !== m_q[0].data || sm_id !== m_q[0].id) begin
                errors++; $display("FAIL wf_drain%0d: got v=%b %h/%0d expected v=1 %h/%0d", n, sm_valid, sm_data, sm_id, m_q[0].data, m_q[0].id);
            end
            last_data = sm_data;
            last_id   = sm_id;
            if (sm_valid === 1'b1) seen++;
            tick();
        end
        #1;
        checks++; if (regs[2] !== 24'h000777) begin errors++; $display("FAIL wf_reg_written: got %h expected 000777", regs[2]); end
`ifdef CONFIG_REGFILE_WRITE_ACK_EN
        checks++; if (last_data !== 24'h0 || last_id !== 4'hA || seen != RD + 1) begin
            errors++; $display("FAIL ack_last: got %h/%h count %0d expected 000000/a count %0d", last_data, last_id, seen, RD + 1);
        end
`else
        checks++; if (seen != RD || last_id !== IDW'(RD)) begin
            errors++; $display("FAIL noack_count: got %0d responses last id %h expected %0d and %h", seen, last_id, RD, IDW'(RD));
        end
`endif
    endtask

    task automatic test_random();
        int off, upper;
        for (int c = 0; c < 600; c++) begin
            off        = $urandom_range(0, 31);
            upper      = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
            ms_valid   = ($urandom_range(0, 3) != 0);
            ms_write   = $urandom_range(0, 1);
            ms_address = {27'(upper), 5'(off)};
            ms_data    = DW'($urandom);
            ms_id      = IDW'($urandom);
            sm_taken   = ($urandom_range(0, 2) != 0);
            irq_src    = NI'($urandom);
            ready      = $urandom_range(0, 1);
            busy       = $urandom_range(0, 1);
            #1;
            checks++; if (ms_taken !== m_taken()) begin errors++; $display("FAIL rnd_taken@%0d: got %b expected %b", c, ms_taken, m_taken()); end
            checks++; if (sm_valid !== (m_q.size() != 0)) begin errors++; $display("FAIL rnd_valid@%0d: got %b expected %b", c, sm_valid, m_q.size() != 0); end
            if (m_q.size() != 0) begin
                checks++; if (sm_data !== m_q[0].data || sm_id !== m_q[0].id) begin
                    errors++; $display("FAIL rnd_head@%0d: got %h/%0d expected %h/%0d", c, sm_data, sm_id, m_q[0].data, m_q[0].id);
                end
            end
            checks++; if (irq_out !== |(m_status & m_enable)) begin errors++; $display("FAIL rnd_irq@%0d: got %b expected %b", c, irq_out, |(m_status & m_enable)); end
            checks++; if (start !== m_ctrl(0) || reset_core !== m_ctrl(1) || flush !== m_ctrl(2)) begin
                errors++; $display("FAIL rnd_pulses@%0d: got s=%b r=%b f=%b expected %b %b %b", c, start, reset_core, flush, m_ctrl(0), m_ctrl(1), m_ctrl(2));
            end
            tick();
        end
        bus_idle();
        sm_taken = 1'b1;
        irq_src  = '0;
        for (int n = 0; n < 8; n++) tick();
        #1;
        for (int k = 0; k < NR; k++) begin
            checks++; if (regs[k] !== m_regs[k]) begin errors++; $display("FAIL rnd_regs[%0d]: got %h expected %h", k, regs[k], m_regs[k]); end
        end
        checks++; if (sm_valid !== 1'b0) begin errors++; $display("FAIL rnd_drained: got %b expected 0", sm_valid); end
    endtask

    initial begin
        bus_idle();
        sm_taken = 1'b1;
        ready    = 1'b0;
        busy     = 1'b0;
        irq_src  = '0;
        m_status = '0;
        m_enable = '0;
        m_prev   = '0;
        for (int k = 0; k < NR; k++) m_regs[k] = '0;
        test_reset();
        test_write_read();
        test_backpressure();
        test_control();
        test_irq();
        test_reset_midop();
        test_write_vs_full();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
